seq_divider: RTL

//  Iterative restoring divider: N-bit dividend / N-bit divisor -> quotient + remainder.
//  One trial subtraction per cycle through an N+1-bit ripple subtractor (Full_Adder chain, B inverted, C_in=1).

---
 rtl/seq_div_pkg.sv | 7 +
 rtl/seq_divider_subtractor.sv | 17 +
 rtl/seq_divider.sv | 99 +++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared FSM state type and iteration-counter sizing for seq_divider
package seq_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/seq_divider_subtractor.sv
// nbit_subtractor: full-adder ripple chain computing a + ~b + 1, carry out is the no-borrow flag
module nbit_subtractor #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d,
  output logic         no_borrow
);
  logic [W:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign d[i]   = a[i] ^ ~b[i] ^ c[i];
    assign c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
  end
  assign no_borrow = c[W];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider with start/done handshake; SEQ_DIV_SIGNED_EN adds signed_op
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic         signed_op,
`endif
  output logic         ready,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);
  localparam int CW = cnt_width(N);
  div_state_t state, state_nx;
  logic [N:0] r, shifted, d;
  logic [N-1:0] q, dvs, a_in, b_in, q_fix, r_fix;
  logic [CW-1:0] cnt;
  logic no_borrow, dz, zero_in;
  assign zero_in = divisor == '0;
  assign shifted = (N+1)'({r, q[N-1]});
`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q, neg_r, sa, sb;
  assign sa    = signed_op & dividend[N-1];
  assign sb    = signed_op & divisor[N-1];
  assign a_in  = zero_in ? dividend : (sa ? -dividend : dividend);
  assign b_in  = sb ? -divisor : divisor;
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -r[N-1:0] : r[N-1:0];
`else
  assign a_in  = dividend;
  assign b_in  = divisor;
  assign q_fix = q;
  assign r_fix = r[N-1:0];
`endif
  nbit_subtractor #(.W(N+1)) u_sub (
    .a(shifted),
    .b({1'b0, dvs}),
    .d(d),
    .no_borrow(no_borrow)
  );
  // State register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  // Next state and handshake: zero divisor skips the iterations entirely
  always_comb begin
    ready    = state == IDLE;
    state_nx = state == IDLE ? (start ? (zero_in ? DONE : RUN) : IDLE)
             : state == RUN  ? (cnt == CW'(N-1) ? DONE : RUN)
             : IDLE;
  end
  // Datapath: latch operands, one restoring step per RUN cycle, register results in DONE
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
      dz        <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        r   <= '0;
        q   <= a_in;
        dvs <= b_in;
        cnt <= '0;
        dz  <= zero_in;
`ifdef SEQ_DIV_SIGNED_EN
        neg_q <= sa ^ sb;
        neg_r <= sa;
`endif
      end else if (state == RUN) begin
        r   <= no_borrow ? d : shifted;
        q   <= {q[N-2:0], no_borrow};
        cnt <= cnt + 1'b1;
      end else if (state == DONE) begin
        done      <= 1'b1;
        quotient  <= dz ? '1 : q_fix;
        remainder <= dz ? q : r_fix;
        div_zero  <= dz;
      end
    end
endmodule
